// File: rtl/if_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | if_stage_pkg                                                         |
// | Shared types and constants for the instruction-fetch stage.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package if_stage_pkg;

    localparam int INST_ADDR_W = 16;
    localparam int INST_W      = 16;

    typedef logic [INST_ADDR_W-1:0] inst_addr_t;
    typedef logic [INST_W-1:0]      inst_t;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } if_state_e;

    // What the IF/ID register does this cycle
    typedef enum logic [1:0] {
        IFID_HOLD    = 2'd0,
        IFID_LOAD    = 2'd1,
        IFID_BUBBLE  = 2'd2,
        IFID_RELEASE = 2'd3
    } ifid_op_e;

    localparam inst_t      NOP_INST_DEF   = 16'h0800;
    localparam inst_addr_t ZERO_INST_ADDR = 16'h0000;

endpackage
`default_nettype wire

// File: rtl/if_stage_if_id_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | if_id_reg                                                            |
// | IF/ID pipeline register plus the one-entry skid buffer behind it.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module if_id_reg
    import if_stage_pkg::*;
#(
    parameter inst_t NOP_INST = NOP_INST_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  ifid_op_e               op,
    input  logic                   skid_load,
    input  logic [INST_W-1:0]      fetch_inst,
    input  logic [INST_ADDR_W-1:0] fetch_pc_inc,
    output logic [INST_W-1:0]      inst,
    output logic [INST_ADDR_W-1:0] pc,
    output logic                   valid
);

    inst_t      skid_inst;
    inst_addr_t skid_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            inst      <= NOP_INST;
            pc        <= ZERO_INST_ADDR;
            valid     <= 1'b0;
            skid_inst <= '0;
            skid_pc   <= ZERO_INST_ADDR;
        end else begin
            case (op)
                IFID_LOAD: begin
                    inst  <= fetch_inst;
                    pc    <= fetch_pc_inc;
                    valid <= 1'b1;
                end
                // A bubble keeps pc so decode's branch base stays meaningful
                IFID_BUBBLE: begin
                    inst  <= NOP_INST;
                    valid <= 1'b0;
                end
                IFID_RELEASE: begin
                    inst  <= skid_inst;
                    pc    <= skid_pc;
                    valid <= 1'b1;
                end
                default: ;
            endcase
            if (skid_load) begin
                skid_inst <= fetch_inst;
                skid_pc   <= fetch_pc_inc;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | if_stage                                                             |
// | Fetch PC, imem req/ack handshake, delayed-branch redirect, IF/ID.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module if_stage
    import if_stage_pkg::*;
#(
    parameter inst_addr_t RESET_PC = 16'h0000,
    parameter inst_t      NOP_INST = NOP_INST_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_i,
    input  logic                   branch_flag_i,
    input  logic [INST_ADDR_W-1:0] branch_addr_i,
    output logic                   imem_req_o,
    output logic [INST_ADDR_W-1:0] imem_addr_o,
    input  logic                   imem_ack_i,
    input  logic [INST_W-1:0]      imem_rdata_i,
    output logic [INST_W-1:0]      inst_o,
    output logic [INST_ADDR_W-1:0] pc_o,
    output logic                   valid_o
);

    if_state_e  state, state_next;
    inst_addr_t fetch_pc, fetch_pc_inc, next_pc;
    inst_addr_t redir_addr;
    logic       redir_pending;
    logic       fetch_ack, release_skid, branch_take, slot_done;
    logic       skid_load;
    ifid_op_e   ifid_op;

    assign fetch_pc_inc = fetch_pc + 16'd1;
    assign next_pc      = redir_pending ? redir_addr : fetch_pc_inc;
    assign imem_addr_o  = fetch_pc;

    // The branch leaves decode this cycle; its delay slot is the word at
    // fetch_pc (or the skid word), which is never squashed.
    assign branch_take = valid_o && !stall_i && !redir_pending && branch_flag_i;
    assign slot_done   = fetch_ack || release_skid;

    always_comb begin
        state_next   = state;
        imem_req_o   = 1'b0;
        fetch_ack    = 1'b0;
        release_skid = 1'b0;
        skid_load    = 1'b0;
        ifid_op      = IFID_HOLD;
        case (state)
            S_BOOT: state_next = S_FETCH;
            S_FETCH: begin
                imem_req_o = 1'b1;
                fetch_ack  = imem_ack_i;
                if (imem_ack_i) begin
                    if (stall_i) begin
                        skid_load  = 1'b1;
                        state_next = S_HOLD;
                    end else begin
                        ifid_op = IFID_LOAD;
                    end
                end else if (!stall_i) begin
                    ifid_op = IFID_BUBBLE;
                end
            end
            S_HOLD: begin
                if (!stall_i) begin
                    release_skid = 1'b1;
                    ifid_op      = IFID_RELEASE;
                    state_next   = S_FETCH;
                end
            end
            default: state_next = S_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_BOOT;
            fetch_pc      <= RESET_PC;
            redir_pending <= 1'b0;
            redir_addr    <= ZERO_INST_ADDR;
        end else begin
            state <= state_next;
            if (branch_take && slot_done) begin
                fetch_pc <= branch_addr_i;
            end else if (fetch_ack) begin
                fetch_pc <= next_pc;
            end
            // Slot still in flight: remember the target until its ack
            if (branch_take && !slot_done) begin
                redir_pending <= 1'b1;
                redir_addr    <= branch_addr_i;
            end else if (fetch_ack) begin
                redir_pending <= 1'b0;
            end
        end
    end

    if_id_reg #(
        .NOP_INST (NOP_INST)
    ) u_if_id_reg (
        .clk          (clk),
        .rst          (rst),
        .op           (ifid_op),
        .skid_load    (skid_load),
        .fetch_inst   (imem_rdata_i),
        .fetch_pc_inc (fetch_pc_inc),
        .inst         (inst_o),
        .pc           (pc_o),
        .valid        (valid_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_if_stage                                                          |
// | Directed bench for if_stage with a word-level fetch model.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst, stall_i, branch_flag_i, imem_ack_i, imem_req_o, valid_o;
    logic [15:0] branch_addr_i, imem_addr_o, imem_rdata_i, inst_o, pc_o;

    always #5 clk = ~clk;

    if_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .branch_flag_i (branch_flag_i),
        .branch_addr_i (branch_addr_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_rdata_i  (imem_rdata_i),
        .inst_o        (inst_o),
        .pc_o          (pc_o),
        .valid_o       (valid_o)
    );

    int total = 0;
    int bad   = 0;
    int n;

    // memory responder and branch source configuration
    int          lat = 1;
    int          wcnt = 0;
    bit          ovr = 1'b0;
    bit          br_en = 1'b0, noise_en = 1'b0, last_flag = 1'b0;
    logic [15:0] br_at = 16'h0000, br_tgt = 16'h0000;

    // word-level model: address wanted next, a word parked by stall,
    // queued redirect targets, and the expected IF/ID contents
    bit          m_boot = 1'b1;
    logic [15:0] m_want = 16'h0000;
    bit          m_held = 1'b0;
    logic [15:0] m_held_inst = 16'h0000, m_held_pc = 16'h0000;
    logic [15:0] m_q[$];
    logic [15:0] e_inst = 16'h0800, e_pc = 16'h0000;
    bit          e_valid = 1'b0;

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit          taken;
        logic [15:0] nxt;
        if (rst) begin
            m_boot = 1'b1; m_want = 16'h0000; m_held = 1'b0; m_q.delete();
            e_inst = 16'h0800; e_pc = 16'h0000; e_valid = 1'b0;
            return;
        end
        if (m_boot) begin
            m_boot = 1'b0;
            return;
        end
        taken = e_valid && !stall_i && branch_flag_i && (m_q.size() == 0);
        if (m_held) begin
            if (!stall_i) begin
                e_inst = m_held_inst; e_pc = m_held_pc; e_valid = 1'b1;
                m_held = 1'b0;
                if (taken) m_want = branch_addr_i;
            end
        end else if (imem_ack_i) begin
            if (taken)                 nxt = branch_addr_i;
            else if (m_q.size() != 0)  nxt = m_q.pop_front();
            else                       nxt = m_want + 16'd1;
            if (stall_i) begin
                m_held = 1'b1; m_held_inst = imem_rdata_i; m_held_pc = m_want + 16'd1;
            end else begin
                e_inst = imem_rdata_i; e_pc = m_want + 16'd1; e_valid = 1'b1;
            end
            m_want = nxt;
        end else begin
            if (!stall_i) begin
                e_inst = 16'h0800; e_valid = 1'b0;
            end
            if (taken) m_q.push_back(branch_addr_i);
        end
    endtask

    task automatic drive();
        if (ovr) begin
            imem_ack_i = 1'b1; imem_rdata_i = 16'hBEEF; wcnt = 0;
        end else if (imem_req_o) begin
            if (wcnt >= lat - 1) begin
                imem_ack_i = 1'b1; imem_rdata_i = imem_addr_o + 16'h1000; wcnt = 0;
            end else begin
                imem_ack_i = 1'b0; imem_rdata_i = 16'hDEAD; wcnt++;
            end
        end else begin
            imem_ack_i = 1'b0; imem_rdata_i = 16'hDEAD; wcnt = 0;
        end
        if (br_en && valid_o && pc_o == br_at + 16'd1) begin
            branch_flag_i = 1'b1; branch_addr_i = br_tgt; last_flag = 1'b1;
        end else if (noise_en && last_flag) begin
            branch_flag_i = 1'b1; branch_addr_i = 16'h0077; last_flag = 1'b0;
        end else begin
            branch_flag_i = 1'b0; branch_addr_i = 16'h0000; last_flag = 1'b0;
        end
    endtask

    // One clock: advance the model on the edge, compare on the falling edge
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk1 ("m_req",   imem_req_o,  !m_boot && !m_held);
        chk16("m_addr",  imem_addr_o, m_want);
        chk16("m_inst",  inst_o,      e_inst);
        chk16("m_pc",    pc_o,        e_pc);
        chk1 ("m_valid", valid_o,     e_valid);
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; stall_i = 1'b0; branch_flag_i = 1'b0; branch_addr_i = 16'h0000;
        imem_ack_i = 1'b0; imem_rdata_i = 16'h0000;

        // single-cycle memory, then a 3-cycle stall on the word at 0x0005
        lat = 1;
        do_reset();
        chk1 ("a_boot_req",   imem_req_o, 1'b0);
        chk1 ("a_boot_valid", valid_o,    1'b0);
        chk16("a_boot_inst",  inst_o,     16'h0800);
        cycle();
        chk16("a_first_addr", imem_addr_o, 16'h0000);
        cycle(); chk16("a_inst0", inst_o, 16'h1000); chk16("a_pc0", pc_o, 16'h0001);
        cycle(); chk16("a_inst1", inst_o, 16'h1001); chk16("a_pc1", pc_o, 16'h0002);
        cycle(); chk16("a_inst2", inst_o, 16'h1002); chk16("a_pc2", pc_o, 16'h0003);
        n = 0;
        while (!(imem_req_o && imem_addr_o == 16'h0005) && n < 40) begin cycle(); n++; end
        chk1("a_reach5", n < 40, 1'b1);
        stall_i = 1'b1;
        cycle();
        chk1 ("a_hold_req",  imem_req_o, 1'b0);
        chk16("a_hold_inst", inst_o,     16'h1004);
        cycle(); cycle();
        chk16("a_hold_pc", pc_o, 16'h0005);
        stall_i = 1'b0;
        cycle();
        chk16("a_rel_inst", inst_o, 16'h1005);
        chk16("a_rel_pc",   pc_o,   16'h0006);
        chk16("a_rel_addr", imem_addr_o, 16'h0006);

        // two-cycle ack latency: one bubble between instructions
        lat = 2;
        do_reset();
        cycle(); cycle();
        chk1 ("b_bub0_valid", valid_o, 1'b0);
        chk16("b_bub0_inst",  inst_o,  16'h0800);
        cycle(); chk16("b_inst0", inst_o, 16'h1000); chk1("b_valid0", valid_o, 1'b1);
        cycle(); chk1("b_bub1_valid", valid_o, 1'b0); chk16("b_bub1_pc", pc_o, 16'h0001);
        cycle(); chk16("b_inst1", inst_o, 16'h1001); chk16("b_pc1", pc_o, 16'h0002);

        // branch 0x10 -> 0x40, delay slot acked in the branch cycle
        lat = 1; br_en = 1'b1; br_at = 16'h0010; br_tgt = 16'h0040;
        do_reset();
        n = 0;
        while (!(imem_req_o && imem_addr_o == 16'h0011) && n < 40) begin cycle(); n++; end
        chk1 ("c_reach", n < 40, 1'b1);
        chk16("c_br_inst", inst_o, 16'h1010);
        cycle();
        chk16("c_tgt_addr",  imem_addr_o, 16'h0040);
        chk16("c_slot_inst", inst_o, 16'h1011);
        chk1 ("c_slot_vld",  valid_o, 1'b1);
        cycle();
        chk16("c_tgt_inst", inst_o, 16'h1040);
        chk16("c_tgt_pc",   pc_o,   16'h0041);

        // same branch with a late delay slot, plus a stray branch while pending
        lat = 2; noise_en = 1'b1;
        do_reset();
        n = 0;
        while (!(valid_o && pc_o == 16'h0011) && n < 80) begin cycle(); n++; end
        chk1("d_reach", n < 80, 1'b1);
        cycle();
        chk1 ("d_wait_valid", valid_o, 1'b0);
        chk16("d_wait_addr",  imem_addr_o, 16'h0011);
        cycle();
        chk16("d_slot_inst", inst_o, 16'h1011);
        chk16("d_tgt_addr",  imem_addr_o, 16'h0040);
        cycle(); cycle();
        chk16("d_tgt_inst", inst_o, 16'h1040);
        chk16("d_tgt_pc",   pc_o,   16'h0041);
        br_en = 1'b0; noise_en = 1'b0;

        // reset while waiting on 0x0023, with a late ack during boot
        lat = 1;
        do_reset();
        n = 0;
        while (!(imem_req_o && imem_addr_o == 16'h0022) && n < 60) begin cycle(); n++; end
        chk1("e_reach", n < 60, 1'b1);
        lat = 3;
        cycle();
        chk16("e_wait_addr", imem_addr_o, 16'h0023);
        rst = 1'b1; ovr = 1'b1;
        cycle();
        chk1 ("e_rst_req",   imem_req_o, 1'b0);
        chk1 ("e_rst_valid", valid_o,    1'b0);
        chk16("e_rst_inst",  inst_o,     16'h0800);
        rst = 1'b0; ovr = 1'b0; lat = 1;
        cycle();
        chk16("e_restart_addr", imem_addr_o, 16'h0000);
        chk1 ("e_late_ack_ign", valid_o, 1'b0);
        cycle();
        chk16("e_restart_inst", inst_o, 16'h1000);

        // branch to 0xFFFF: pc_o of that word wraps to 0x0000
        br_en = 1'b1; br_at = 16'h0002; br_tgt = 16'hFFFF;
        do_reset();
        n = 0;
        while (!(imem_req_o && imem_addr_o == 16'h0003) && n < 20) begin cycle(); n++; end
        chk1("f_reach", n < 20, 1'b1);
        cycle();
        chk16("f_tgt_addr", imem_addr_o, 16'hFFFF);
        cycle();
        br_en = 1'b0;
        chk16("f_wrap_inst", inst_o, 16'h0FFF);
        chk16("f_wrap_pc",   pc_o,   16'h0000);
        chk16("f_wrap_addr", imem_addr_o, 16'h0000);
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
`default_nettype wire
